// File: rtl/dtack_generator.sv
// Bus-cycle termination for the 68000 local bus: registered DTACK_L with per-region
// wait states, forwarded device acknowledges for DRAM/CAN, and BERR_L on timeout.
module dtack_generator #(
  parameter int unsigned ROM_WAIT       = 0,
  parameter int unsigned RAM_WAIT       = 0,
  parameter int unsigned IO_WAIT        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic Clk,
  input  logic Reset_L,
  input  logic AS_L,
  input  logic UDS_L,
  input  logic LDS_L,
  input  logic OnChipRomSelect_H,
  input  logic OnChipRamSelect_H,
  input  logic IOSelect_H,
  input  logic DramSelect_H,
  input  logic CanBusSelect_H,
  input  logic DramDtack_L,
  input  logic CanBusDtack_L,
  output logic DTACK_L,
  output logic BERR_L,
  output logic BusTimeout_H,
  output logic CycleActive_H
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIXWAIT,
    S_EXTWAIT,
    S_ACK,
    S_BERR
  } state_t;

  typedef enum logic [2:0] {
    R_NONE,
    R_ROM,
    R_RAM,
    R_IO,
    R_DRAM,
    R_CAN
  } region_t;

  localparam logic [7:0]  ROM_W    = 8'(ROM_WAIT);
  localparam logic [7:0]  RAM_W    = 8'(RAM_WAIT);
  localparam logic [7:0]  IO_W     = 8'(IO_WAIT);
  // Timeout fires on the edge where the counter would step onto TIMEOUT_CYCLES-1.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 2);

  state_t      state_q;
  region_t     region_q;
  logic [7:0]  waitCnt_q;
  logic [15:0] tmoCnt_q;
  logic        dtack_q;
  logic        berr_q;
  logic        busTimeout_q;
  logic        cycleActive_q;

  region_t     region_d;
  logic [7:0]  waitLoad_d;
  logic        cycleStart;
  logic        ackNow;
  logic        timeoutNow;

  assign cycleStart = !AS_L && (!UDS_L || !LDS_L);

  always_comb begin
    region_d   = R_NONE;
    waitLoad_d = 8'd0;
    if (OnChipRomSelect_H) begin
      region_d   = R_ROM;
      waitLoad_d = ROM_W;
    end else if (OnChipRamSelect_H) begin
      region_d   = R_RAM;
      waitLoad_d = RAM_W;
    end else if (IOSelect_H) begin
      region_d   = R_IO;
      waitLoad_d = IO_W;
    end else if (DramSelect_H) begin
      region_d = R_DRAM;
    end else if (CanBusSelect_H) begin
      region_d = R_CAN;
    end
  end

  always_comb begin
    ackNow = 1'b0;
    if (state_q == S_FIXWAIT) begin
      ackNow = (waitCnt_q == 8'd0);
    end else if (state_q == S_EXTWAIT) begin
      ackNow = ((region_q == R_DRAM) && !DramDtack_L) ||
               ((region_q == R_CAN)  && !CanBusDtack_L);
    end
  end

  assign timeoutNow = (tmoCnt_q == TMO_LAST);

  // Abort beats ack, ack beats timeout; all outputs are registered with the state.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q       <= S_IDLE;
      region_q      <= R_NONE;
      waitCnt_q     <= 8'd0;
      tmoCnt_q      <= 16'd0;
      dtack_q       <= 1'b1;
      berr_q        <= 1'b1;
      busTimeout_q  <= 1'b0;
      cycleActive_q <= 1'b0;
    end else begin
      busTimeout_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cycleStart) begin
            region_q      <= region_d;
            tmoCnt_q      <= 16'd0;
            cycleActive_q <= 1'b1;
            if ((region_d == R_ROM) || (region_d == R_RAM) || (region_d == R_IO)) begin
              waitCnt_q <= waitLoad_d;
              state_q   <= S_FIXWAIT;
            end else begin
              state_q <= S_EXTWAIT;
            end
          end
        end
        S_FIXWAIT, S_EXTWAIT: begin
          if (AS_L) begin
            state_q       <= S_IDLE;
            cycleActive_q <= 1'b0;
          end else if (ackNow) begin
            state_q <= S_ACK;
            dtack_q <= 1'b0;
          end else if (timeoutNow) begin
            state_q      <= S_BERR;
            berr_q       <= 1'b0;
            busTimeout_q <= 1'b1;
          end else begin
            if (tmoCnt_q != 16'hFFFF) begin
              tmoCnt_q <= tmoCnt_q + 16'd1;
            end
            if ((state_q == S_FIXWAIT) && (waitCnt_q != 8'd0)) begin
              waitCnt_q <= waitCnt_q - 8'd1;
            end
          end
        end
        S_ACK, S_BERR: begin
          if (AS_L) begin
            state_q       <= S_IDLE;
            dtack_q       <= 1'b1;
            berr_q        <= 1'b1;
            cycleActive_q <= 1'b0;
          end
        end
        default: begin
          state_q       <= S_IDLE;
          dtack_q       <= 1'b1;
          berr_q        <= 1'b1;
          cycleActive_q <= 1'b0;
        end
      endcase
    end
  end

  assign DTACK_L       = dtack_q;
  assign BERR_L        = berr_q;
  assign BusTimeout_H  = busTimeout_q;
  assign CycleActive_H = cycleActive_q;

endmodule

// File: tb/tb_dtack_generator.sv
// Directed bench for dtack_generator: two instances (IO_WAIT=2 and IO_WAIT=5),
// both with TIMEOUT_CYCLES=16, driven from shared inputs.
module tb_dtack_generator;

  logic Clk = 1'b0;
  logic Reset_L;
  logic AS_L, UDS_L, LDS_L;
  logic OnChipRomSelect_H, OnChipRamSelect_H, IOSelect_H, DramSelect_H, CanBusSelect_H;
  logic DramDtack_L, CanBusDtack_L;
  logic DTACK_L, BERR_L, BusTimeout_H, CycleActive_H;
  logic DTACK2_L, BERR2_L, BusTimeout2_H, CycleActive2_H;

  int passCount  = 0;
  int checkCount = 0;

  always #5 Clk = ~Clk;

  dtack_generator #(.ROM_WAIT(0), .RAM_WAIT(1), .IO_WAIT(2), .TIMEOUT_CYCLES(16)) dut (
    .Clk(Clk), .Reset_L(Reset_L), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .OnChipRomSelect_H(OnChipRomSelect_H), .OnChipRamSelect_H(OnChipRamSelect_H),
    .IOSelect_H(IOSelect_H), .DramSelect_H(DramSelect_H), .CanBusSelect_H(CanBusSelect_H),
    .DramDtack_L(DramDtack_L), .CanBusDtack_L(CanBusDtack_L),
    .DTACK_L(DTACK_L), .BERR_L(BERR_L), .BusTimeout_H(BusTimeout_H),
    .CycleActive_H(CycleActive_H)
  );

  dtack_generator #(.ROM_WAIT(0), .RAM_WAIT(1), .IO_WAIT(5), .TIMEOUT_CYCLES(16)) dut2 (
    .Clk(Clk), .Reset_L(Reset_L), .AS_L(AS_L), .UDS_L(UDS_L), .LDS_L(LDS_L),
    .OnChipRomSelect_H(OnChipRomSelect_H), .OnChipRamSelect_H(OnChipRamSelect_H),
    .IOSelect_H(IOSelect_H), .DramSelect_H(DramSelect_H), .CanBusSelect_H(CanBusSelect_H),
    .DramDtack_L(DramDtack_L), .CanBusDtack_L(CanBusDtack_L),
    .DTACK_L(DTACK2_L), .BERR_L(BERR2_L), .BusTimeout_H(BusTimeout2_H),
    .CycleActive_H(CycleActive2_H)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("FAIL %s: observed %b expected %b", tag, observed, expected);
  endtask

  task automatic idleBus();
    AS_L = 1'b1; UDS_L = 1'b1; LDS_L = 1'b1;
    OnChipRomSelect_H = 1'b0; OnChipRamSelect_H = 1'b0; IOSelect_H = 1'b0;
    DramSelect_H = 1'b0; CanBusSelect_H = 1'b0;
    DramDtack_L = 1'b1; CanBusDtack_L = 1'b1;
  endtask

  initial begin
    idleBus();
    Reset_L = 1'b0;
    tick(); tick();
    check("rst_dtack", DTACK_L, 1'b1);
    check("rst_berr", BERR_L, 1'b1);
    check("rst_timeout", BusTimeout_H, 1'b0);
    check("rst_active", CycleActive_H, 1'b0);
    Reset_L = 1'b1;
    tick();

    // ROM, zero waits: DTACK at N+1, held until AS_L seen high
    OnChipRomSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    check("rom_n_dtack", DTACK_L, 1'b1);
    check("rom_n_active", CycleActive_H, 1'b1);
    tick();
    check("rom_n1_dtack", DTACK_L, 1'b0);
    tick(); tick(); tick();
    check("rom_n4_dtack_held", DTACK_L, 1'b0);
    idleBus();
    tick();
    check("rom_end_dtack", DTACK_L, 1'b1);
    check("rom_end_berr", BERR_L, 1'b1);
    check("rom_end_active", CycleActive_H, 1'b0);
    tick();

    // IO, two waits; select switched to ROM after N must not be relatched
    IOSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
    tick();
    check("io_n_active", CycleActive_H, 1'b1);
    IOSelect_H = 1'b0; OnChipRomSelect_H = 1'b1;
    tick();
    check("io_n1_dtack", DTACK_L, 1'b1);
    tick();
    check("io_n2_dtack", DTACK_L, 1'b1);
    tick();
    check("io_n3_dtack", DTACK_L, 1'b0);
    check("io_n3_active", CycleActive_H, 1'b1);
    idleBus();
    tick();
    check("io_end_dtack", DTACK_L, 1'b1);
    check("io_end_active", CycleActive_H, 1'b0);
    tick();

    // DRAM: CanBusDtack_L toggling is ignored; DramDtack_L low acks that edge
    DramSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0; LDS_L = 1'b0;
    tick();
    for (int i = 1; i <= 6; i++) begin
      CanBusDtack_L = ~CanBusDtack_L;
      tick();
    end
    check("dram_n6_dtack", DTACK_L, 1'b1);
    CanBusDtack_L = 1'b1;
    DramDtack_L = 1'b0;
    tick();
    check("dram_n7_dtack", DTACK_L, 1'b0);
    idleBus();
    tick();
    check("dram_end_dtack", DTACK_L, 1'b1);
    tick();

    // Unmapped: BERR at N+15 with one-clock timeout pulse
    AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    for (int i = 1; i <= 14; i++) tick();
    check("nomap_n14_berr", BERR_L, 1'b1);
    check("nomap_n14_timeout", BusTimeout_H, 1'b0);
    tick();
    check("nomap_n15_berr", BERR_L, 1'b0);
    check("nomap_n15_timeout", BusTimeout_H, 1'b1);
    check("nomap_n15_dtack", DTACK_L, 1'b1);
    tick();
    check("nomap_n16_timeout", BusTimeout_H, 1'b0);
    check("nomap_n16_berr", BERR_L, 1'b0);
    idleBus();
    tick();
    check("nomap_end_berr", BERR_L, 1'b1);
    check("nomap_end_active", CycleActive_H, 1'b0);
    tick();

    // CAN ack on the timeout edge: ack wins
    CanBusSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
    tick();
    for (int i = 1; i <= 14; i++) tick();
    check("coll_n14_dtack", DTACK_L, 1'b1);
    CanBusDtack_L = 1'b0;
    tick();
    check("coll_dtack", DTACK_L, 1'b0);
    check("coll_berr", BERR_L, 1'b1);
    check("coll_timeout", BusTimeout_H, 1'b0);
    idleBus();
    tick();
    check("coll_end_dtack", DTACK_L, 1'b1);
    tick();

    // Abort mid-FIXWAIT on the IO_WAIT=5 instance
    IOSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    check("abort_n_active", CycleActive2_H, 1'b1);
    tick(); tick();
    idleBus();
    tick();
    check("abort_active", CycleActive2_H, 1'b0);
    check("abort_dtack", DTACK2_L, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    check("abort_late_dtack", DTACK2_L, 1'b1);
    check("abort_late_berr", BERR2_L, 1'b1);

    // Reset asynchronously while in ACK, then a normal ROM cycle
    OnChipRamSelect_H = 1'b1; AS_L = 1'b0; UDS_L = 1'b0;
    tick();
    tick();
    check("ram_n1_dtack", DTACK_L, 1'b1);
    tick();
    check("ram_n2_dtack", DTACK_L, 1'b0);
    Reset_L = 1'b0;
    #2;
    check("rst_mid_dtack", DTACK_L, 1'b1);
    check("rst_mid_active", CycleActive_H, 1'b0);
    idleBus();
    #1;
    Reset_L = 1'b1;
    tick();
    check("post_rst_idle", CycleActive_H, 1'b0);
    OnChipRomSelect_H = 1'b1; AS_L = 1'b0; LDS_L = 1'b0;
    tick();
    check("post_rst_n_active", CycleActive_H, 1'b1);
    tick();
    check("post_rst_dtack", DTACK_L, 1'b0);
    idleBus();
    tick();
    check("post_rst_end_dtack", DTACK_L, 1'b1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dtack_generator.md
Name: dtack_generator

Overview:
- Bus-cycle termination controller for the 68000 local bus, downstream of the address decoder.
- Consumes the decoder's region-select outputs plus the CPU strobes, and generates DTACK_L with per-region programmable wait states.
- DRAM and CAN regions are terminated by forwarding their own device acknowledge.
- An unanswered cycle, including one to an unmapped address, is terminated with BERR_L after a timeout.

Parameters:
- ROM_WAIT, 0, wait states inserted for on-chip ROM cycles (0..255)
- RAM_WAIT, 0, wait states for on-chip RAM cycles (0..255)
- IO_WAIT, 2, wait states for IO cycles (0..255)
- TIMEOUT_CYCLES, 1024, clocks from cycle start until BERR_L is asserted (2..65535)

Ports:
- Clk  in  1  system clock; all state changes on the rising edge
- Reset_L  in  1  asynchronous, active-low reset
- AS_L  in  1  CPU address strobe
- UDS_L  in  1  upper data strobe
- LDS_L  in  1  lower data strobe
- OnChipRomSelect_H  in  1  decoder select
- OnChipRamSelect_H  in  1  decoder select
- IOSelect_H  in  1  decoder select
- DramSelect_H  in  1  decoder select
- CanBusSelect_H  in  1  decoder select
- DramDtack_L  in  1  acknowledge from the DRAM controller
- CanBusDtack_L  in  1  acknowledge from the CAN interface
- DTACK_L  out  1  registered data acknowledge to the CPU
- BERR_L  out  1  registered bus error to the CPU
- BusTimeout_H  out  1  one-clock pulse when a timeout fires
- CycleActive_H  out  1  high in any state other than IDLE

Behaviour:
- Reset (Reset_L low, asynchronous): state IDLE; DTACK_L=1, BERR_L=1, BusTimeout_H=0, CycleActive_H=0; both counters 0. Reset wins over everything, including mid-cycle.
- Qualifying edge N: a rising edge with state IDLE, AS_L=0, and (UDS_L=0 or LDS_L=0).
- Region latching at edge N: region is latched, with priority ROM > RAM > IO > DRAM > CAN > NONE. The latched region is held for the whole cycle; later select changes are ignored.
- States: IDLE, FIXWAIT, EXTWAIT, ACK, BERR.
- IDLE transition at edge N:
  - ROM/RAM/IO -> FIXWAIT, wait counter (8-bit) loaded with the region's *_WAIT value.
  - DRAM/CAN/NONE -> EXTWAIT.
  - Timeout counter (16-bit) cleared in both cases.
- FIXWAIT:
  - On each edge with wait counter != 0: decrement the wait counter.
  - On the edge where the wait counter == 0: -> ACK and DTACK_L=0. DTACK_L therefore falls at edge N+W+1.
- EXTWAIT:
  - On an edge where the latched region's device ack is sampled low (DramDtack_L for DRAM, CanBusDtack_L for CAN): -> ACK, DTACK_L=0 at that edge.
  - NONE never acks.
- Timeout (FIXWAIT and EXTWAIT): the timeout counter increments each edge. At the edge where it would reach TIMEOUT_CYCLES-1, and no ack is taken on the same edge:
  - -> BERR, BERR_L=0.
  - BusTimeout_H=1 for exactly that one clock.
  - BERR_L therefore falls at edge N+TIMEOUT_CYCLES-1.
- Ack/timeout collision: if ack and timeout occur on the same edge, ack wins and BERR_L stays high.
- ACK / BERR exit: hold DTACK_L (or BERR_L) low until AS_L is sampled high. At that edge -> IDLE and the output returns to 1.
  - DTACK_L and BERR_L are never low simultaneously.
- Aborted cycle: AS_L sampled high while in FIXWAIT or EXTWAIT -> IDLE with no DTACK and no BERR.
- Back-to-back cycles: a new qualifying edge is recognised only from IDLE, so at least one IDLE clock separates cycles.
- Overflow: counters never wrap; the timeout counter saturates, since the state is left first.

Test Plan:
- ROM read, ROM_WAIT=0:
  - Stimulus: AS_L and LDS_L low at edge 10, held low.
  - Required: DTACK_L low from edge 11 until AS_L is sampled high at edge 15; DTACK_L high after edge 15; BERR_L stays 1.
- IO cycle, IO_WAIT=2:
  - Stimulus: qualify at edge 20.
  - Required: DTACK_L low at edge 23, not before; CycleActive_H high from edge 20 until return to IDLE.
- DRAM cycle:
  - Stimulus: qualify at edge 5; DramDtack_L first sampled low at edge 12.
  - Required: DTACK_L low at edge 12; CanBusDtack_L toggling during the cycle has no effect.
- Unmapped address, TIMEOUT_CYCLES=16:
  - Stimulus: no select, qualify at edge 0.
  - Required: BERR_L low at edge 15; BusTimeout_H high for one clock; DTACK_L stays 1; BERR_L high after AS_L is sampled high.
- Ack/timeout collision and abort:
  - Stimulus A: CAN cycle with CanBusDtack_L low exactly at the timeout edge. Required: DTACK_L=0, BERR_L=1.
  - Stimulus B: AS_L raised mid-FIXWAIT with IO_WAIT=5. Required: return to IDLE with no DTACK.
- Reset mid-cycle:
  - Stimulus: Reset_L pulsed low asynchronously while in ACK.
  - Required: DTACK_L=1 immediately; state IDLE; a following cycle behaves normally.
